// File: rtl/mem_dma.sv
`default_nettype none
// ============================================================================
// Module   : mem_dma
// Brief    : Byte block-transfer engine (copy / fill) on the data-memory port.
// Revision : 1.0 - initial release
// ============================================================================
module mem_dma #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] address,
  output logic              writeEn,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              write_en_q, write_en_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [ADDR_W-1:0] last_idx;

  // len of zero wraps to all-ones here, giving a full 2^ADDR_W transfer
  assign last_idx = len_q - ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = len;
          fill_d  = fill_value;
          idx_d   = '0;
          state_d = mode ? WRITE : READ;
        end
      end
      READ: begin
        buf_d   = read_data;
        state_d = WRITE;
      end
      WRITE: begin
        if (idx_q == last_idx) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = mode_q ? WRITE : READ;
        end
      end
      default: state_d = IDLE;
    endcase

    // Port outputs are decoded from the next state so they register alongside it
    busy_d       = (state_d == READ) || (state_d == WRITE);
    done_d       = (state_d == DONE);
    write_en_d   = 1'b1;
    address_d    = '0;
    write_data_d = '0;
    case (state_d)
      READ: address_d = src_d + idx_d;
      WRITE: begin
        address_d    = dst_d + idx_d;
        write_en_d   = 1'b0;
        write_data_d = mode_d ? fill_d : buf_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      buf_q        <= '0;
      mode_q       <= 1'b0;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      fill_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      address_q    <= '0;
      write_en_q   <= 1'b1;
      write_data_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      buf_q        <= buf_d;
      mode_q       <= mode_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      fill_q       <= fill_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      address_q    <= address_d;
      write_en_q   <= write_en_d;
      write_data_q <= write_data_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign address    = address_q;
  assign writeEn    = write_en_q;
  assign write_data = write_data_q;

endmodule
`default_nettype wire
